uart_run: RTL and testbench

// - Full-duplex UART core, 8N1 format: 1 start bit, 8 data bits LSB-first, 1 stop bit, no parity; line idles high.
// - Transmitter serialises d_in on txd when write is asserted.
// - Receiver deserialises rxd into d_out and pulses get for each good byte.
// - Sits between the system-clock logic and the board serial pins. Bit timing comes from one shared clock divider setting.

---
 rtl/uart_run.sv | 141 ++++++++++++++
 tb/tb_uart_run.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_run.sv
// Full-duplex 8N1 UART: TX serialises d_in on write, RX deserialises rxd into d_out/get.
// Latency: txd start bit 1 clk after write is sampled; get ~9.5 bit times after start edge; no backpressure (write ignored while busy).
module uart_run #(
  parameter int HW_MODE = 1
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] d_in,
  input  logic       write,
  input  logic       rxd,
  output logic       txd,
  output logic [7:0] d_out,
  output logic       get
);

  localparam int BIT  = (HW_MODE != 0) ? 10416 : 8;
  localparam int HALF = BIT / 2;
  localparam int CW   = $clog2(BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        tx_state, tx_next;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_idx;
  logic [7:0]    tx_shift;
  logic          tx_bit_end;
  logic          txd_nxt;

  assign tx_bit_end = (tx_cnt == BIT_LAST);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) tx_state <= IDLE;
    else       tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      IDLE:    if (write) tx_next = START;
      START:   if (tx_bit_end) tx_next = DATA;
      DATA:    if (tx_bit_end && tx_idx == 3'd7) tx_next = STOP;
      STOP:    if (tx_bit_end) tx_next = write ? START : IDLE;
      default: tx_next = IDLE;
    endcase
  end

  always_comb begin
    txd_nxt = 1'b1;
    case (tx_state)
      START:   txd_nxt = 1'b0;
      DATA:    txd_nxt = tx_shift[0];
      default: txd_nxt = 1'b1;
    endcase
  end

  // txd is registered so the pin never sees decode glitches.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      txd      <= 1'b1;
      tx_cnt   <= '0;
      tx_idx   <= 3'd0;
      tx_shift <= 8'h00;
    end else begin
      txd <= txd_nxt;
      if (tx_state == IDLE || tx_bit_end) tx_cnt <= '0;
      else                                tx_cnt <= tx_cnt + CW'(1);
      if (tx_next == START && tx_state != START) begin
        tx_shift <= d_in;
      end else if (tx_state == DATA && tx_bit_end) begin
        tx_shift <= {1'b0, tx_shift[7:1]};
        tx_idx   <= tx_idx + 3'd1;
      end
    end
  end

  logic          rx_sync1, rx_s, rx_prev;
  state_t        rx_state, rx_next;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_idx;
  logic [7:0]    rx_data;
  logic          rx_wrap;
  logic          rx_done;

  // Synchroniser flops reset to the idle level so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      rx_sync1 <= 1'b1;
      rx_s     <= 1'b1;
      rx_prev  <= 1'b1;
    end else begin
      rx_sync1 <= rxd;
      rx_s     <= rx_sync1;
      rx_prev  <= rx_s;
    end
  end

  assign rx_wrap = (rx_state == START) ? (rx_cnt == HALF_LAST) : (rx_cnt == BIT_LAST);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) rx_state <= IDLE;
    else       rx_state <= rx_next;
  end

  // A start needs a falling edge, so a line stuck low after a framing error is ignored.
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      IDLE:    if (!rx_s && rx_prev) rx_next = START;
      START:   if (rx_wrap) rx_next = rx_s ? IDLE : DATA;
      DATA:    if (rx_wrap && rx_idx == 3'd7) rx_next = STOP;
      STOP:    if (rx_wrap) rx_next = IDLE;
      default: rx_next = IDLE;
    endcase
  end

  always_comb begin
    rx_done = (rx_state == STOP) && rx_wrap && rx_s;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      rx_cnt  <= '0;
      rx_idx  <= 3'd0;
      rx_data <= 8'h00;
      d_out   <= 8'h00;
      get     <= 1'b0;
    end else begin
      if (rx_state == IDLE || rx_wrap) rx_cnt <= '0;
      else                             rx_cnt <= rx_cnt + CW'(1);
      if (rx_state == DATA && rx_wrap) begin
        rx_data[rx_idx] <= rx_s;
        rx_idx          <= rx_idx + 3'd1;
      end
      get <= rx_done;
      if (rx_done) d_out <= rx_data;
    end
  end

endmodule

// File: tb/tb_uart_run.sv
// Randomised self-checking bench for uart_run in simulation mode (8 clk per bit).
`timescale 1ns/1ps
module tb_uart_run;
  localparam int BIT = 8;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic [7:0] d_in = 8'h00;
  logic       write = 1'b0;
  logic       rxd = 1'b1;
  logic       txd;
  logic [7:0] d_out;
  logic       get;

  uart_run #(.HW_MODE(0)) dut (
    .clk(clk), .clrn(clrn), .d_in(d_in), .write(write), .rxd(rxd),
    .txd(txd), .d_out(d_out), .get(get)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  logic [7:0] last_good = 8'h00;
  logic [7:0] got_q[$];
  int         got_t[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (clrn && get) begin
      got_q.push_back(d_out);
      got_t.push_back(cyc);
    end
  end

  // Line level of bit slot i of an 8N1 frame carrying b.
  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[3'(i - 1)];
    return 1'b1;
  endfunction

  task automatic rx_bit(input logic v, input int n);
    rxd = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    for (int i = 0; i < 10; i++) rx_bit((i == 9) ? stop : frame_bit(b, i), BIT);
  endtask

  task automatic tx_frame(input logic [7:0] b);
    d_in = b; write = 1'b1;
    @(negedge clk);
    write = 1'b0; d_in = ~b;
    vectors++;
    if (txd !== 1'b1) begin errors++; $display("FAIL tx_pre_start txd=%b expected 1", txd); end
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      vectors++;
      if (txd !== frame_bit(b, i / BIT)) begin
        errors++; $display("FAIL tx_frame byte=%h slot=%0d txd=%b expected %b", b, i / BIT, txd, frame_bit(b, i / BIT));
      end
    end
  endtask

  task automatic check_rx(input string name, input logic [7:0] exp_q[$]);
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL %s get_count=%0d expected %0d", name, got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        vectors++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL %s byte%0d d_out=%h expected %h", name, i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      write = 1'($urandom_range(0, 1)); rxd = 1'($urandom_range(0, 1)); d_in = 8'($urandom);
      vectors += 3;
      if (txd !== 1'b1)    begin errors++; $display("FAIL reset_txd txd=%b expected 1", txd); end
      if (d_out !== 8'h00) begin errors++; $display("FAIL reset_dout d_out=%h expected 00", d_out); end
      if (get !== 1'b0)    begin errors++; $display("FAIL reset_get get=%b expected 0", get); end
    end
    write = 1'b0; rxd = 1'b1;
    @(negedge clk);
    clrn = 1'b1;
    repeat (4) begin
      @(negedge clk);
      vectors += 2;
      if (txd !== 1'b1) begin errors++; $display("FAIL post_reset_txd txd=%b expected 1", txd); end
      if (get !== 1'b0) begin errors++; $display("FAIL post_reset_get get=%b expected 0", get); end
    end
  endtask

  task automatic test_tx();
    tx_frame(8'h6E);
    for (int n = 0; n < 3; n++) tx_frame(8'($urandom));
    repeat (10) begin
      @(negedge clk);
      vectors++;
      if (txd !== 1'b1) begin errors++; $display("FAIL tx_idle txd=%b expected 1", txd); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] dv[25];
    int starts[$];
    int s;
    logic exp;
    foreach (dv[i]) dv[i] = 8'($urandom);
    s = 0;
    while (s < 25) begin starts.push_back(s); s += 10; end
    d_in = dv[0]; write = 1'b1;
    for (int k = 1; k <= 8 * 40; k++) begin
      @(negedge clk);
      exp = 1'b1;
      if (k >= 2) begin
        foreach (starts[f]) begin
          if ((k - 2) / BIT >= starts[f] && (k - 2) / BIT < starts[f] + 10)
            exp = frame_bit(dv[starts[f]], (k - 2) / BIT - starts[f]);
        end
      end
      vectors++;
      if (txd !== exp) begin errors++; $display("FAIL back_to_back k=%0d txd=%b expected %b", k, txd, exp); end
      if (k < 25 * BIT) d_in = dv[k / BIT];
      else              write = 1'b0;
    end
  endtask

  task automatic test_rx_known();
    int t0;
    logic [7:0] exp_q[$];
    got_q.delete(); got_t.delete();
    t0 = cyc;
    send_rx(8'hA5, 1'b1);
    rx_bit(1'b1, 16);
    exp_q.push_back(8'hA5);
    check_rx("rx_a5", exp_q);
    last_good = 8'hA5;
    if (got_t.size() > 0) begin
      vectors++;
      if (got_t[0] - t0 < 9 * BIT || got_t[0] - t0 > 10 * BIT + 4) begin
        errors++; $display("FAIL rx_a5_latency cycles=%0d expected 72..84", got_t[0] - t0);
      end
    end
    vectors++;
    if (d_out !== 8'hA5) begin errors++; $display("FAIL rx_a5_hold d_out=%h expected a5", d_out); end
  endtask

  task automatic test_rx_all_ones();
    logic [7:0] exp_q[$];
    got_q.delete(); got_t.delete();
    repeat (3) begin
      rx_bit(1'b0, BIT);
      rx_bit(1'b1, 14 * BIT);
      exp_q.push_back(8'hFF);
    end
    check_rx("rx_all_ones", exp_q);
    last_good = 8'hFF;
    for (int i = 1; i < got_t.size(); i++) begin
      vectors++;
      if (got_t[i] - got_t[i-1] != 15 * BIT) begin
        errors++; $display("FAIL rx_all_ones_period cycles=%0d expected 120", got_t[i] - got_t[i-1]);
      end
    end
  endtask

  task automatic test_glitch();
    logic [7:0] b;
    logic [7:0] exp_q[$];
    got_q.delete();
    rx_bit(1'b0, 2);
    rx_bit(1'b1, 40);
    check_rx("glitch_no_get", exp_q);
    vectors++;
    if (d_out !== last_good) begin errors++; $display("FAIL glitch_dout d_out=%h expected %h", d_out, last_good); end
    b = 8'($urandom);
    send_rx(b, 1'b1);
    rx_bit(1'b1, BIT);
    exp_q.push_back(b);
    check_rx("glitch_rearm", exp_q);
    last_good = b;
  endtask

  task automatic test_framing();
    logic [7:0] b;
    logic [7:0] exp_q[$];
    got_q.delete();
    send_rx(8'h3C, 1'b0);
    rx_bit(1'b0, 20);
    rx_bit(1'b1, 2 * BIT);
    check_rx("framing_no_get", exp_q);
    vectors++;
    if (d_out !== last_good) begin errors++; $display("FAIL framing_dout d_out=%h expected %h", d_out, last_good); end
    b = 8'($urandom);
    send_rx(b, 1'b1);
    rx_bit(1'b1, BIT);
    exp_q.push_back(b);
    check_rx("framing_recover", exp_q);
    last_good = b;
  endtask

  task automatic test_rx_random();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    got_q.delete();
    for (int n = 0; n < 6; n++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_rx(b, 1'b1);
    end
    rx_bit(1'b1, BIT);
    check_rx("rx_back_to_back", exp_q);
    last_good = b;
  endtask

  task automatic test_full_duplex();
    logic [7:0] bt, br;
    logic [7:0] exp_q[$];
    got_q.delete();
    bt = 8'($urandom); br = 8'($urandom);
    fork
      tx_frame(bt);
      begin send_rx(br, 1'b1); rx_bit(1'b1, 4); end
    join
    exp_q.push_back(br);
    check_rx("full_duplex_rx", exp_q);
    last_good = br;
  endtask

  task automatic test_reset_midframe();
    logic [7:0] exp_q[$];
    got_q.delete();
    d_in = 8'h00; write = 1'b1;
    @(negedge clk);
    write = 1'b0; rxd = 1'b0;
    repeat (20) @(negedge clk);
    vectors++;
    if (txd !== 1'b0) begin errors++; $display("FAIL midframe_txd_busy txd=%b expected 0", txd); end
    clrn = 1'b0;
    #1;
    vectors += 2;
    if (txd !== 1'b1)    begin errors++; $display("FAIL midframe_abort_txd txd=%b expected 1", txd); end
    if (d_out !== 8'h00) begin errors++; $display("FAIL midframe_abort_dout d_out=%h expected 00", d_out); end
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    clrn = 1'b1;
    for (int i = 0; i < 90; i++) begin
      @(negedge clk);
      vectors++;
      if (txd !== 1'b1) begin errors++; $display("FAIL midframe_release_txd cycle=%0d txd=%b expected 1", i, txd); end
    end
    check_rx("midframe_no_get", exp_q);
  endtask

  initial begin
    test_reset();
    test_tx();
    test_back_to_back();
    test_rx_known();
    test_rx_all_ones();
    test_glitch();
    test_framing();
    test_rx_random();
    test_full_duplex();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
